// File: rtl/iris_seq_ctrl_if.sv
// Feature-stream and result-port bundle for iris_seq_ctrl.
// WIDTH_A and OUTWIDTH must match the parameters of the attached controller.
interface iris_seq_ctrl_if #(
  parameter int unsigned WIDTH_A  = 4,
  parameter int unsigned OUTWIDTH = 2
);
  logic                feat_valid;
  logic                feat_ready;
  logic [WIDTH_A-1:0]  feat_data;
  logic                res_valid;
  logic                res_ready;
  logic [OUTWIDTH-1:0] res_class;

  // Controller side: sinks features, sources results.
  modport slave (
    input  feat_valid, feat_data, res_ready,
    output feat_ready, res_valid, res_class
  );

  // Sample source / result consumer side.
  modport master (
    output feat_valid, feat_data, res_ready,
    input  feat_ready, res_valid, res_class
  );
endinterface

// File: rtl/iris_seq_ctrl.sv
// Sequencing controller for the combinational Iris classifier: gathers
// NUM_A feature words into the packed inp vector, waits SETTLE cycles for
// the classifier to resolve, then captures and presents the class code.
module iris_seq_ctrl #(
  parameter int unsigned NUM_A    = 4,
  parameter int unsigned WIDTH_A  = 4,
  parameter int unsigned OUTWIDTH = 2,
  parameter int unsigned SETTLE   = 2,
  parameter int unsigned CNTW     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  iris_seq_ctrl_if.slave             bus,
  output logic [NUM_A*WIDTH_A-1:0]   inp,
  input  logic [OUTWIDTH-1:0]        out,
  output logic                       busy,
  output logic [CNTW-1:0]            sample_cnt
);

  localparam int unsigned IDXW  = (NUM_A > 1) ? $clog2(NUM_A) : 1;
  localparam int unsigned CNTSW = $clog2(SETTLE + 1);
  localparam logic [IDXW-1:0]  IDX_LAST = IDXW'(NUM_A - 1);
  localparam logic [CNTSW-1:0] CNT_LAST = CNTSW'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t                          state_q, state_d;
  logic [IDXW-1:0]                 idx_q, idx_d;
  logic [CNTSW-1:0]                cnt_q, cnt_d;
  logic [NUM_A-1:0][WIDTH_A-1:0]   lane_q;
  logic                            lane_we;
  logic                            res_valid_q, res_valid_d;
  logic [OUTWIDTH-1:0]             res_class_q, res_class_d;
  logic [CNTW-1:0]                 sample_cnt_q, sample_cnt_d;
  logic                            feat_ready_c;
  logic                            accept_c;

  // Ready is a decode of the state so it rises in the first cycle after reset
  // release; it is forced low while reset is held.
  assign feat_ready_c = (state_q == ST_LOAD) && !rst;
  assign accept_c     = bus.feat_valid && feat_ready_c;

  // Next-state and register-update decode.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    lane_we      = 1'b0;
    res_valid_d  = res_valid_q;
    res_class_d  = res_class_q;
    sample_cnt_d = sample_cnt_q;
    case (state_q)
      ST_LOAD: begin
        if (accept_c) begin
          lane_we = 1'b1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            cnt_d   = '0;
            state_d = ST_SETTLE;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q + CNTSW'(1);
        if (cnt_q == CNT_LAST) begin
          res_class_d = out;
          res_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (res_valid_q && bus.res_ready) begin
          res_valid_d  = 1'b0;
          sample_cnt_d = sample_cnt_q + CNTW'(1);
          state_d      = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // State and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_LOAD;
      idx_q        <= '0;
      cnt_q        <= '0;
      res_valid_q  <= 1'b0;
      res_class_q  <= '0;
      sample_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      res_valid_q  <= res_valid_d;
      res_class_q  <= res_class_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  // Feature lanes; untouched lanes keep the previous sample's value.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= '0;
    end else if (lane_we) begin
      lane_q[idx_q] <= bus.feat_data;
    end
  end

  assign bus.feat_ready = feat_ready_c;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_class  = res_class_q;
  assign inp            = lane_q;
  assign sample_cnt     = sample_cnt_q;
  assign busy           = !rst && ((state_q != ST_LOAD) || (idx_q != '0));

endmodule

// File: tb/tb_iris_seq_ctrl.sv
// Directed bench for iris_seq_ctrl: a default instance with a combinational
// classifier stub, plus SETTLE=1/CNTW=2 and SETTLE=3 instances whose stub
// answers one cycle after inp changes.
module tb_iris_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  iris_seq_ctrl_if #(.WIDTH_A(4), .OUTWIDTH(2)) bm ();
  iris_seq_ctrl_if #(.WIDTH_A(4), .OUTWIDTH(2)) b1 ();
  iris_seq_ctrl_if #(.WIDTH_A(4), .OUTWIDTH(2)) b3 ();

  logic [15:0] inp_m, inp_1, inp_3;
  logic [1:0]  out_m, out_1_q, out_3_q;
  logic        busy_m, busy_1, busy_3;
  logic [15:0] cnt_m, cnt_3;
  logic [1:0]  cnt_1;

  // Classifier stubs: immediate for the main instance, one-cycle late otherwise.
  assign out_m = inp_m[1:0];
  always @(posedge clk) begin
    out_1_q <= inp_1[13:12];
    out_3_q <= inp_3[13:12];
  end

  iris_seq_ctrl u_m (
    .clk(clk), .rst(rst), .bus(bm), .inp(inp_m), .out(out_m),
    .busy(busy_m), .sample_cnt(cnt_m)
  );

  iris_seq_ctrl #(.SETTLE(1), .CNTW(2)) u_1 (
    .clk(clk), .rst(rst), .bus(b1), .inp(inp_1), .out(out_1_q),
    .busy(busy_1), .sample_cnt(cnt_1)
  );

  iris_seq_ctrl #(.SETTLE(3)) u_3 (
    .clk(clk), .rst(rst), .bus(b3), .inp(inp_3), .out(out_3_q),
    .busy(busy_3), .sample_cnt(cnt_3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy_s(input int sel);
    return (sel == 1) ? b1.feat_ready : b3.feat_ready;
  endfunction

  function automatic logic rv_s(input int sel);
    return (sel == 1) ? b1.res_valid : b3.res_valid;
  endfunction

  // Offer one word to the selected side instance and wait for its acceptance.
  task automatic push_s(input int sel, input logic [3:0] w);
    int n;
    n = 0;
    if (sel == 1) begin b1.feat_valid = 1'b1; b1.feat_data = w; end
    else          begin b3.feat_valid = 1'b1; b3.feat_data = w; end
    while (!rdy_s(sel) && n < 10) begin tick(); n++; end
    if (!rdy_s(sel)) begin
      total++;
      $display("FAIL push_s%0d: feat_ready timeout", sel);
    end
    tick();
    b1.feat_valid = 1'b0;
    b3.feat_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bm.feat_valid = 1'b1; bm.feat_data = 4'hF; bm.res_ready = 1'b1;
    b1.feat_valid = 1'b1; b1.feat_data = 4'hF; b1.res_ready = 1'b1;
    b3.feat_valid = 1'b1; b3.feat_data = 4'hF; b3.res_ready = 1'b1;
    repeat (3) tick();
    total++; if (bm.feat_ready !== 1'b0) $display("FAIL reset_feat_ready: got %0b want 0", bm.feat_ready); else passed++;
    total++; if (bm.res_valid !== 1'b0) $display("FAIL reset_res_valid: got %0b want 0", bm.res_valid); else passed++;
    total++; if (bm.res_class !== 2'd0) $display("FAIL reset_res_class: got %0d want 0", bm.res_class); else passed++;
    total++; if (inp_m !== 16'h0000) $display("FAIL reset_inp: got %h want 0000", inp_m); else passed++;
    total++; if (busy_m !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy_m); else passed++;
    total++; if (cnt_m !== 16'd0) $display("FAIL reset_sample_cnt: got %0d want 0", cnt_m); else passed++;
    rst = 1'b0;
    bm.feat_valid = 1'b0; bm.res_ready = 1'b0;
    b1.feat_valid = 1'b0; b1.res_ready = 1'b0;
    b3.feat_valid = 1'b0; b3.res_ready = 1'b0;
    #1;
    total++; if (bm.feat_ready !== 1'b1) $display("FAIL release_feat_ready: got %0b want 1", bm.feat_ready); else passed++;
    tick();
    total++; if ({busy_m, inp_m} !== 17'd0) $display("FAIL release_idle: got busy=%0b inp=%h want 0/0000", busy_m, inp_m); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  w [8];
    int          acc [8];
    int          rise [2];
    logic [1:0]  cls [2];
    logic [15:0] inp_s [2];
    int          n, hs, nr;
    logic        rv_prev;
    w = '{4'd5, 4'd3, 4'd1, 4'd0, 4'd6, 4'd2, 4'd7, 4'd4};
    n = 0; hs = 0; nr = 0;
    rise[0] = -1; rise[1] = -1;
    inp_s[0] = 16'hxxxx; inp_s[1] = 16'hxxxx;
    cls[0] = 2'bxx; cls[1] = 2'bxx;
    bm.res_ready = 1'b1;
    rv_prev = bm.res_valid;
    for (int c = 0; c < 40 && hs < 2; c++) begin
      bm.feat_valid = (n < 8);
      bm.feat_data  = (n < 8) ? w[n & 7] : 4'd0;
      if (bm.feat_valid && bm.feat_ready) begin acc[n & 7] = c; n++; end
      if (bm.res_valid && bm.res_ready) hs++;
      tick();
      if (n == 4 && acc[3] == c) inp_s[0] = inp_m;
      if (n == 8 && acc[7] == c) inp_s[1] = inp_m;
      if (bm.res_valid && !rv_prev && nr < 2) begin
        rise[nr] = c; cls[nr] = bm.res_class; nr++;
      end
      rv_prev = bm.res_valid;
    end
    bm.feat_valid = 1'b0;
    bm.res_ready  = 1'b0;
    if (hs < 2) begin total++; $display("FAIL b2b_timeout: got %0d handshakes want 2", hs); end
    total++; if (inp_s[0] !== 16'h0135) $display("FAIL b2b_inp0: got %h want 0135", inp_s[0]); else passed++;
    total++; if (inp_s[1] !== 16'h4726) $display("FAIL b2b_inp1: got %h want 4726", inp_s[1]); else passed++;
    total++; if (rise[0] !== acc[3] + 2) $display("FAIL b2b_latency: got %0d want %0d", rise[0] - acc[3], 2); else passed++;
    total++; if (cls[0] !== 2'd1) $display("FAIL b2b_class0: got %0d want 1", cls[0]); else passed++;
    total++; if (cls[1] !== 2'd2) $display("FAIL b2b_class1: got %0d want 2", cls[1]); else passed++;
    total++; if (acc[4] - acc[0] !== 7) $display("FAIL b2b_period: got %0d want 7", acc[4] - acc[0]); else passed++;
    total++; if (acc[7] - acc[3] !== 7) $display("FAIL b2b_period2: got %0d want 7", acc[7] - acc[3]); else passed++;
    total++; if (cnt_m !== 16'd2) $display("FAIL b2b_sample_cnt: got %0d want 2", cnt_m); else passed++;
  endtask

  task automatic test_gapped();
    logic [3:0]  w [4];
    logic [15:0] base;
    int          n;
    w = '{4'd9, 4'd10, 4'd11, 4'd12};
    base = cnt_m;
    bm.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bm.feat_valid = 1'b1; bm.feat_data = w[i];
      tick();
      bm.feat_valid = 1'b0;
      if (i < 3) tick();
    end
    n = 0;
    while (!bm.res_valid && n < 10) begin tick(); n++; end
    total++; if (n !== 2) $display("FAIL gap_latency: got %0d want 2", n); else passed++;
    total++; if (inp_m !== 16'hCBA9) $display("FAIL gap_inp: got %h want cba9", inp_m); else passed++;
    for (int i = 0; i < 5; i++) begin
      bm.feat_valid = 1'b1; bm.feat_data = 4'hF;
      #1;
      total++;
      if ({bm.feat_ready, bm.res_valid, bm.res_class} !== 4'b0101)
        $display("FAIL gap_hold%0d: got rdy=%0b rv=%0b cls=%0d want 0/1/1", i, bm.feat_ready, bm.res_valid, bm.res_class);
      else passed++;
      tick();
    end
    bm.feat_valid = 1'b0;
    total++; if (inp_m !== 16'hCBA9) $display("FAIL gap_inp_held: got %h want cba9", inp_m); else passed++;
    total++; if (cnt_m !== base) $display("FAIL gap_cnt_before: got %0d want %0d", cnt_m, base); else passed++;
    bm.res_ready = 1'b1;
    tick();
    bm.res_ready = 1'b0;
    total++; if (bm.res_valid !== 1'b0) $display("FAIL gap_rv_drop: got %0b want 0", bm.res_valid); else passed++;
    total++; if (cnt_m !== 16'(base + 16'd1)) $display("FAIL gap_cnt_after: got %0d want %0d", cnt_m, base + 16'd1); else passed++;
    repeat (2) tick();
    total++; if (cnt_m !== 16'(base + 16'd1)) $display("FAIL gap_cnt_once: got %0d want %0d", cnt_m, base + 16'd1); else passed++;
    total++; if (bm.feat_ready !== 1'b1) $display("FAIL gap_back_to_load: got %0b want 1", bm.feat_ready); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [3:0] w [4];
    int         n;
    w = '{4'd1, 4'd2, 4'd3, 4'd4};
    bm.feat_valid = 1'b1;
    bm.feat_data = 4'd7; tick();
    bm.feat_data = 4'd8; tick();
    bm.feat_valid = 1'b0;
    total++; if ({busy_m, inp_m} !== {1'b1, 16'hCB87}) $display("FAIL mid_partial: got busy=%0b inp=%h want 1/cb87", busy_m, inp_m); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++; if (inp_m !== 16'h0000) $display("FAIL mid_inp_cleared: got %h want 0000", inp_m); else passed++;
    total++; if (busy_m !== 1'b0) $display("FAIL mid_idx_cleared: got busy=%0b want 0", busy_m); else passed++;
    total++; if (cnt_m !== 16'd0) $display("FAIL mid_cnt_cleared: got %0d want 0", cnt_m); else passed++;
    bm.feat_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bm.feat_data = w[i];
      tick();
    end
    bm.feat_valid = 1'b0;
    total++; if (inp_m !== 16'h4321) $display("FAIL mid_fresh_inp: got %h want 4321", inp_m); else passed++;
    n = 0;
    while (!bm.res_valid && n < 10) begin tick(); n++; end
    total++; if (bm.res_class !== 2'd1) $display("FAIL mid_class: got %0d want 1", bm.res_class); else passed++;
    total++; if (cnt_m !== 16'd0) $display("FAIL mid_cnt_pending: got %0d want 0", cnt_m); else passed++;
    bm.res_ready = 1'b1;
    tick();
    bm.res_ready = 1'b0;
    total++; if (cnt_m !== 16'd1) $display("FAIL mid_cnt_done: got %0d want 1", cnt_m); else passed++;
  endtask

  task automatic test_cnt_wrap();
    logic [1:0] exp_cnt [5];
    int         n;
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int s = 0; s < 5; s++) begin
      for (int i = 0; i < 4; i++) push_s(1, 4'd1);
      n = 0;
      while (!b1.res_valid && n < 10) begin tick(); n++; end
      b1.res_ready = 1'b1;
      tick();
      b1.res_ready = 1'b0;
      total++; if (cnt_1 !== exp_cnt[s]) $display("FAIL wrap_cnt%0d: got %0d want %0d", s, cnt_1, exp_cnt[s]); else passed++;
    end
  endtask

  task automatic test_settle();
    int n;
    for (int i = 0; i < 3; i++) push_s(1, 4'd0);
    push_s(1, 4'd2);
    n = 0;
    while (!rv_s(1) && n < 10) begin tick(); n++; end
    total++; if (n !== 1) $display("FAIL settle1_latency: got %0d want 1", n); else passed++;
    total++; if (b1.res_class !== 2'd1) $display("FAIL settle1_stale_class: got %0d want 1", b1.res_class); else passed++;
    b1.res_ready = 1'b1; tick(); b1.res_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_s(3, 4'd0);
    push_s(3, 4'd3);
    n = 0;
    while (!rv_s(3) && n < 10) begin tick(); n++; end
    total++; if (n !== 3) $display("FAIL settle3_latency: got %0d want 3", n); else passed++;
    total++; if (b3.res_class !== 2'd3) $display("FAIL settle3_class: got %0d want 3", b3.res_class); else passed++;
    b3.res_ready = 1'b1; tick(); b3.res_ready = 1'b0;
    total++; if (cnt_3 !== 16'd1) $display("FAIL settle3_cnt: got %0d want 1", cnt_3); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    bm.feat_valid = 1'b0; bm.feat_data = 4'd0; bm.res_ready = 1'b0;
    b1.feat_valid = 1'b0; b1.feat_data = 4'd0; b1.res_ready = 1'b0;
    b3.feat_valid = 1'b0; b3.feat_data = 4'd0; b3.res_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_gapped();
    test_reset_mid();
    test_cnt_wrap();
    test_settle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
